// File: rtl/tl_mem_slave.sv
// TileLink-UL memory target: Get / PutFullData / PutPartialData, single beat or bursts up to 64 bytes.
// Optional macro TL_MEM_DELAY_EN inserts RESP_DELAY wait cycles ahead of every D response.
module tl_mem_slave #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 16,
  parameter int RESP_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [2:0]        a_size,
  input  logic [3:0]        a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [7:0]        a_mask,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [2:0]        d_size,
  output logic [3:0]        d_source,
  output logic [1:0]        d_sink,
  output logic              d_denied,
  output logic [DATA_W-1:0] d_data,
  output logic              d_corrupt,
  output logic              d_valid,
  input  logic              d_ready
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_BURST = 3'd1;
  localparam logic [2:0] WR_BURST = 3'd2;
  localparam logic [2:0] ACK      = 3'd3;
  localparam logic [2:0] DENY     = 3'd4;
  localparam int IW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << IW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  logic [2:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [3:0]    last_reg, a_last;
  logic [IW-1:0] base_reg, a_base, rd_idx, wr_idx;
  logic          get_reg, deny_reg;
  logic          accept, d_fire, in_resp, wait_done;
  logic          a_is_get, a_has_data, a_get_ok, a_put_ok;
  logic          rd_en, wr_en;

  // Beats minus one; size 7 is sized as 16 beats so a denied Put drains completely.
  always_comb begin
    case (a_size)
      3'd4:    a_last = 4'd1;
      3'd5:    a_last = 4'd3;
      3'd6:    a_last = 4'd7;
      3'd7:    a_last = 4'd15;
      default: a_last = 4'd0;
    endcase
  end

  assign a_base     = a_address[IW+2:3] & ~IW'(a_last);
  assign a_is_get   = (a_opcode == 3'd4);
  assign a_has_data = !a_opcode[2];
  assign a_get_ok   = a_is_get && (a_size != 3'd7);
  assign a_put_ok   = (a_opcode[2:1] == 2'b00) && (a_size != 3'd7);

  assign accept  = a_valid && a_ready;
  assign in_resp = (state_reg == RD_BURST) || (state_reg == ACK) || (state_reg == DENY);
  assign d_valid = in_resp && wait_done;
  assign d_fire  = d_valid && d_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (accept) begin
        cnt_next = 4'd0;
        if (a_get_ok) state_next = RD_BURST;
        else if (a_has_data && a_last != 4'd0) begin
          state_next = WR_BURST;
          cnt_next   = 4'd1;
        end
        else if (a_put_ok) state_next = ACK;
        else state_next = DENY;
      end
      WR_BURST: if (accept) begin
        if (cnt_reg == last_reg) begin
          state_next = deny_reg ? DENY : ACK;
          cnt_next   = 4'd0;
        end
        else cnt_next = cnt_reg + 4'd1;
      end
      RD_BURST: if (d_fire) begin
        if (cnt_reg == last_reg) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
        else cnt_next = cnt_reg + 4'd1;
      end
      ACK, DENY: if (d_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      a_ready   <= 1'b0;
      base_reg  <= '0;
      last_reg  <= 4'd0;
      get_reg   <= 1'b0;
      deny_reg  <= 1'b0;
      d_size    <= 3'd0;
      d_source  <= 4'd0;
    end
    else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_ready   <= (state_next == IDLE) || (state_next == WR_BURST);
      if (state_reg == IDLE && accept) begin
        base_reg <= a_base;
        last_reg <= a_last;
        get_reg  <= a_is_get;
        deny_reg <= !(a_put_ok || a_get_ok);
        d_size   <= a_size;
        d_source <= a_source;
      end
    end
  end

`ifdef TL_MEM_DELAY_EN
  localparam int DLW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY + 1) : 1;
  logic [DLW-1:0] delay_reg;
  logic           resp_entry;

  assign resp_entry = ((state_reg == IDLE) || (state_reg == WR_BURST)) &&
                      ((state_next == RD_BURST) || (state_next == ACK) || (state_next == DENY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) delay_reg <= '0;
    else if (resp_entry) delay_reg <= DLW'(RESP_DELAY);
    else if (delay_reg != '0) delay_reg <= delay_reg - 1'b1;
  end

  assign wait_done = (delay_reg == '0);
`else
  assign wait_done = 1'b1;
`endif

  // Read port prefetches the next beat on each consumed beat so bursts stream back-to-back.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = a_base;
    if (state_reg == IDLE) rd_en = accept && a_get_ok;
    else if (state_reg == RD_BURST) begin
      rd_en  = d_fire && (cnt_reg != last_reg);
      rd_idx = base_reg + IW'(cnt_next);
    end
  end

  assign wr_en  = accept && (((state_reg == IDLE) && a_put_ok) ||
                             ((state_reg == WR_BURST) && !deny_reg));
  assign wr_idx = (state_reg == WR_BURST) ? base_reg + IW'(cnt_reg) : a_base;

  always_ff @(posedge clk) begin
    if (rd_en) rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (a_mask[b]) mem[wr_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  assign d_opcode  = d_valid ? {2'b00, (state_reg == RD_BURST) || ((state_reg == DENY) && get_reg)} : 3'd0;
  assign d_denied  = d_valid && (state_reg == DENY);
  assign d_data    = (d_valid && state_reg == RD_BURST) ? rd_word : '0;
  assign d_param   = 2'd0;
  assign d_sink    = 2'd0;
  assign d_corrupt = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{a_param, a_address[ADDR_W-1:IW+3], a_address[2:0], (RESP_DELAY != 0)};
endmodule

// File: tb/tb_tl_mem_slave.sv
// Self-checking bench for tl_mem_slave: directed scenarios plus random traffic against a
// word-level reference memory (associative array, unwritten word i reads back as i).
module tb_tl_mem_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [3:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_valid, a_ready;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param, d_sink;
  logic [3:0]  d_source;
  logic        d_denied, d_corrupt, d_valid, d_ready;
  logic [63:0] d_data;

`ifdef TL_MEM_DELAY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  int vectors = 0;
  int misc    = 0;
  logic [63:0] ref_mem [int];

  tl_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_valid(a_valid),
    .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      misc++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_rd(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 64'(idx);
  endfunction

  function automatic void ref_wr(input int idx, input logic [63:0] data, input logic [7:0] mask);
    logic [63:0] cur = ref_rd(idx);
    for (int b = 0; b < 8; b++) if (mask[b]) cur[8*b +: 8] = data[8*b +: 8];
    ref_mem[idx] = cur;
  endfunction

  function automatic int beats(input int size);
    return (size <= 3) ? 1 : (1 << size) / 8;
  endfunction

  // Burst-aligned byte address, then word index of beat k modulo the array depth.
  function automatic int word_idx(input logic [63:0] addr, input int size, input int k);
    logic [63:0] nbytes, aligned;
    nbytes  = (size <= 3) ? 64'd8 : (64'd1 << size);
    aligned = addr - (addr % nbytes);
    return int'(((aligned / 64'd8) + 64'(k)) % 64'd65536);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                           input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int n = 0;
    a_opcode = op; a_param = 3'($urandom); a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_valid = 1'b1;
    while (a_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("a_ready_wait", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
  endtask

  task automatic check_latency();
    for (int i = 0; i < LAT; i++) begin
      chk("resp_wait_d_valid", 64'(d_valid), 64'd0);
      chk("resp_wait_a_ready", 64'(a_ready), 64'd0);
      tick();
    end
    chk("first_d_valid", 64'(d_valid), 64'd1);
  endtask

  // One complete transaction; dbase == 0 means random write data, else beat k carries dbase + k.
  task automatic do_txn(input int op, input int size, input logic [3:0] src, input logic [63:0] addr,
                        input logic [7:0] mask, input logic [63:0] dbase, input logic [3:0] pat);
    int  n      = beats(size);
    bit  ok_get = (op == 4) && (size != 7);
    bit  ok_put = (op == 0 || op == 1) && (size != 7);
    logic [63:0] wd;
    if (op <= 3) begin
      for (int k = 0; k < n; k++) begin
        wd = (dbase == 64'd0) ? {$urandom, $urandom} : dbase + 64'(k);
        if (k > 0) chk("wr_burst_a_ready", 64'(a_ready), 64'd1);
        if (ok_put) ref_wr(word_idx(addr, size, k), wd, mask);
        send_beat(3'(op), 3'(size), src, addr, mask, wd);
      end
    end
    else send_beat(3'(op), 3'(size), src, addr, mask, 64'd0);
    chk("req_done_a_ready", 64'(a_ready), 64'd0);
    check_latency();
    if (ok_get) begin
      int k = 0, cyc = 0;
      while (k < n && cyc < 200) begin
        d_ready = pat[cyc % 4];
        chk("rd_valid", 64'(d_valid), 64'd1);
        chk("rd_opcode", 64'(d_opcode), 64'd1);
        chk("rd_denied", 64'(d_denied), 64'd0);
        chk("rd_source", 64'(d_source), 64'(src));
        chk("rd_size", 64'(d_size), 64'(size));
        chk("rd_data", d_data, ref_rd(word_idx(addr, size, k)));
        chk("rd_a_ready", 64'(a_ready), 64'd0);
        tick();
        cyc++;
        if (d_ready) k++;
      end
      chk("rd_beats_consumed", 64'(k), 64'(n));
    end
    else begin
      d_ready = 1'b1;
      chk("ack_opcode", 64'(d_opcode), (op == 4) ? 64'd1 : 64'd0);
      chk("ack_denied", 64'(d_denied), ok_put ? 64'd0 : 64'd1);
      chk("ack_source", 64'(d_source), 64'(src));
      chk("ack_size", 64'(d_size), 64'(size));
      if (!ok_put) chk("deny_data", d_data, 64'd0);
      tick();
    end
    d_ready = 1'b1;
    chk("end_d_valid", 64'(d_valid), 64'd0);
    chk("end_a_ready", 64'(a_ready), 64'd1);
    $display("txn op=%0d size=%0d src=%0h addr=%0h beats=%0d", op, size, src, addr, n);
  endtask

  initial begin
    int ops [8] = '{0, 1, 4, 4, 2, 3, 5, 6};
    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0; a_source = 4'd0;
    a_address = 64'd0; a_mask = 8'd0; a_data = 64'd0;
    // RAM power-up image for simulation: word[i] = i.
    for (int i = 0; i < 65536; i++) dut.mem[i] <= 64'(i);
    tick(); tick();
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_d_denied", 64'(d_denied), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_d_size", 64'(d_size), 64'd0);
    chk("rst_d_source", 64'(d_source), 64'd0);
    rst_n = 1'b1;
    chk("rel_a_ready_low", 64'(a_ready), 64'd0);
    tick();
    chk("rel_a_ready_high", 64'(a_ready), 64'd1);

    do_txn(4, 6, 4'h3, 64'h40000, 8'hFF, 64'd0, 4'hF);
    chk("initial_word_8000", ref_rd(word_idx(64'h40000, 6, 0)), 64'h8000);
    do_txn(0, 6, 4'h5, 64'h200, 8'hFF, 64'hAAAA, 4'hF);
    do_txn(4, 6, 4'h6, 64'h200, 8'hFF, 64'd0, 4'hF);
    do_txn(4, 6, 4'h7, 64'h1000, 8'hFF, 64'd0, 4'b1001);
    do_txn(1, 3, 4'h8, 64'h8, 8'hF0, 64'hFFFFFFFF_FFFFFFFF, 4'hF);
    do_txn(4, 3, 4'h9, 64'h8, 8'hFF, 64'd0, 4'hF);
    chk("partial_merge_model", ref_rd(1), 64'hFFFFFFFF_00000001);
    do_txn(1, 3, 4'h1, 64'h30, 8'h0F, 64'h1122334455667788, 4'hF);
    do_txn(4, 3, 4'h1, 64'h30, 8'hFF, 64'd0, 4'hF);
    do_txn(2, 3, 4'hA, 64'h10, 8'hFF, 64'h5555, 4'hF);
    do_txn(4, 7, 4'hB, 64'h10, 8'hFF, 64'd0, 4'hF);
    do_txn(4, 3, 4'hC, 64'h10, 8'hFF, 64'd0, 4'hF);
    do_txn(0, 7, 4'hD, 64'h300, 8'hFF, 64'd0, 4'hF);
    do_txn(4, 6, 4'hD, 64'h300, 8'hFF, 64'd0, 4'hF);
    do_txn(4, 6, 4'hE, 64'h80000, 8'hFF, 64'd0, 4'hF);
    do_txn(4, 6, 4'hE, 64'h1238, 8'hFF, 64'd0, 4'b0110);

    // Reset while read beat 3 is on the D channel.
    send_beat(3'd4, 3'd6, 4'h2, 64'h2000, 8'hFF, 64'd0);
    check_latency();
    d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_burst_data", d_data, ref_rd(word_idx(64'h2000, 6, k)));
      tick();
    end
    chk("rst_burst_beat3", d_data, ref_rd(word_idx(64'h2000, 6, 3)));
    rst_n = 1'b0;
    #1;
    chk("midrst_d_valid", 64'(d_valid), 64'd0);
    chk("midrst_a_ready", 64'(a_ready), 64'd0);
    chk("midrst_d_data", d_data, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk("midrel_a_ready_low", 64'(a_ready), 64'd0);
    tick();
    chk("midrel_a_ready_high", 64'(a_ready), 64'd1);
    do_txn(4, 6, 4'h2, 64'h2000, 8'hFF, 64'd0, 4'hF);

    for (int t = 0; t < 40; t++) begin
      int op   = ops[$urandom_range(0, 7)];
      int size = $urandom_range(0, 7);
      logic [63:0] addr = {$urandom, $urandom};
      logic [7:0]  mask = (op == 0) ? 8'hFF : 8'($urandom);
      if (t % 3 == 0) addr = {52'd0, 12'($urandom)};
      do_txn(op, size, 4'($urandom), addr, mask, 64'd0, 4'($urandom_range(1, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
